// File: rtl/duck_flight_pkg.sv
// Shared types for the duck flight controller: FSM state encoding and LFSR taps.
package duck_flight_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SPAWN  = 3'd1,
      FLY    = 3'd2,
      SHOT   = 3'd3,
      FALL   = 3'd4,
      ESCAPE = 3'd5
   } duck_state_e;

   // Galois right-shift form of x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/duck_lfsr16.sv
// Free-running 16-bit Galois LFSR with enable; shared source of pseudo-random spawn data.
module duck_lfsr16
   import duck_flight_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [15:0] lfsr_q
);

   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (en) begin
         lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

endmodule

// File: rtl/duck_flight_ctl.sv
// Duck position generator: spawn, fly with edge bounces, shot/fall, escape on timeout.
//   state  | meaning
//   IDLE   | no duck; waits for a hunt_start rising edge
//   SPAWN  | one cycle: place duck at random x on the grass line
//   FLY    | moves diagonally each tick, bounces off screen edges
//   SHOT   | frozen for SHOT_TICKS ticks after a hit
//   FALL   | drops to the grass line, then pulses duck_fell
//   ESCAPE | rises straight up to the top edge, then pulses duck_escaped
module duck_flight_ctl
   import duck_flight_pkg::*;
#(
   parameter int          MOVE_DIV   = 650_000,
   parameter int          SCREEN_W   = 1024,
   parameter int          DUCK_W     = 64,
   parameter int          DUCK_H     = 64,
   parameter int          GROUND_Y   = 600,
   parameter int          SPEED      = 4,
   parameter int          FALL_SPEED = 8,
   parameter int          FLY_TICKS  = 500,
   parameter int          SHOT_TICKS = 30,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        game_enable,
   input  logic        hunt_start,
   input  logic        duck_hit,
   output logic [11:0] duck_xpos,
   output logic [11:0] duck_ypos,
   output logic        duck_visible,
   output logic        duck_dir_right,
   output logic [2:0]  duck_state,
   output logic        duck_escaped,
   output logic        duck_fell
);

   localparam logic [11:0] XMAX     = 12'(SCREEN_W - DUCK_W);
   localparam logic [11:0] YMAX     = 12'(GROUND_Y - DUCK_H);
   localparam logic [11:0] SPD      = 12'(SPEED);
   localparam logic [11:0] FALL_SPD = 12'(FALL_SPEED);
   localparam int TCW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam int FCW = ($clog2(FLY_TICKS + 1) > 5) ? $clog2(FLY_TICKS + 1) : 5;
   localparam int SCW = (SHOT_TICKS > 1) ? $clog2(SHOT_TICKS) : 1;
   localparam logic [TCW-1:0] TICK_LOAD = TCW'(MOVE_DIV - 1);
   localparam logic [SCW-1:0] SHOT_LOAD = SCW'(SHOT_TICKS - 1);
   localparam logic [FCW-1:0] FLY_LAST  = FCW'(FLY_TICKS - 1);

   duck_state_e    state_q, state_d;
   logic [11:0]    x_q, x_d, y_q, y_d;
   logic           right_q, right_d, up_q, up_d;
   logic           visible_q, visible_d;
   logic           escaped_q, escaped_d, fell_q, fell_d;
   logic           hunt_prev_q, hunt_prev_d;
   logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
   logic [FCW-1:0] fly_cnt_q, fly_cnt_d;
   logic [SCW-1:0] shot_cnt_q, shot_cnt_d;
   logic           tick, right_n;
   logic [15:0]    lfsr_q;
   logic [11:0]    spawn_raw, spawn_x;
   logic           lfsr_unused;

   duck_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .en     (1'b1),
      .lfsr_q (lfsr_q)
   );

   assign lfsr_unused = ^lfsr_q[15:11];
   assign spawn_raw   = {2'b00, lfsr_q[9:0]};
   assign spawn_x     = (spawn_raw > XMAX) ? spawn_raw - 12'd512 : spawn_raw;

   // Movement timer reloads in IDLE so the first tick lands MOVE_DIV cycles after SPAWN.
   assign tick = (state_q != IDLE) && (tick_cnt_q == '0);

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      right_d     = right_q;
      up_d        = up_q;
      fly_cnt_d   = fly_cnt_q;
      shot_cnt_d  = shot_cnt_q;
      escaped_d   = 1'b0;
      fell_d      = 1'b0;
      right_n     = right_q;
      hunt_prev_d = hunt_start;
      if (state_q == IDLE || tick_cnt_q == '0) begin
         tick_cnt_d = TICK_LOAD;
      end else begin
         tick_cnt_d = tick_cnt_q - TCW'(1);
      end

      if (!game_enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (hunt_start && !hunt_prev_q) state_d = SPAWN;
            end
            SPAWN: begin
               x_d       = spawn_x;
               y_d       = YMAX;
               right_d   = lfsr_q[10];
               up_d      = 1'b1;
               fly_cnt_d = '0;
               state_d   = FLY;
            end
            FLY: begin
               if (duck_hit) begin
                  shot_cnt_d = SHOT_LOAD;
                  state_d    = SHOT;
               end else if (tick) begin
                  if (right_q) begin
                     if (x_q + SPD > XMAX) begin
                        x_d     = XMAX;
                        right_n = 1'b0;
                     end else begin
                        x_d = x_q + SPD;
                     end
                  end else if (x_q < SPD) begin
                     x_d     = '0;
                     right_n = 1'b1;
                  end else begin
                     x_d = x_q - SPD;
                  end
                  if (up_q) begin
                     if (y_q < SPD) begin
                        y_d  = '0;
                        up_d = 1'b0;
                     end else begin
                        y_d = y_q - SPD;
                     end
                  end else if (y_q + SPD > YMAX) begin
                     y_d  = YMAX;
                     up_d = 1'b1;
                  end else begin
                     y_d = y_q + SPD;
                  end
                  right_d   = (fly_cnt_q[4:0] == 5'd31) ? (right_n ^ lfsr_q[0]) : right_n;
                  fly_cnt_d = fly_cnt_q + FCW'(1);
                  if (fly_cnt_q == FLY_LAST) state_d = ESCAPE;
               end
            end
            SHOT: begin
               if (tick) begin
                  if (shot_cnt_q == '0) begin
                     state_d = FALL;
                  end else begin
                     shot_cnt_d = shot_cnt_q - SCW'(1);
                  end
               end
            end
            FALL: begin
               if (tick) begin
                  if (y_q + FALL_SPD >= YMAX) begin
                     y_d     = YMAX;
                     fell_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     y_d = y_q + FALL_SPD;
                  end
               end
            end
            ESCAPE: begin
               if (tick) begin
                  if (y_q < SPD) begin
                     y_d       = '0;
                     escaped_d = 1'b1;
                     state_d   = IDLE;
                  end else begin
                     y_d = y_q - SPD;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
      visible_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         right_q     <= 1'b0;
         up_q        <= 1'b0;
         visible_q   <= 1'b0;
         escaped_q   <= 1'b0;
         fell_q      <= 1'b0;
         hunt_prev_q <= 1'b0;
         tick_cnt_q  <= TICK_LOAD;
         fly_cnt_q   <= '0;
         shot_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         right_q     <= right_d;
         up_q        <= up_d;
         visible_q   <= visible_d;
         escaped_q   <= escaped_d;
         fell_q      <= fell_d;
         hunt_prev_q <= hunt_prev_d;
         tick_cnt_q  <= tick_cnt_d;
         fly_cnt_q   <= fly_cnt_d;
         shot_cnt_q  <= shot_cnt_d;
      end
   end

   assign duck_xpos      = x_q;
   assign duck_ypos      = y_q;
   assign duck_visible   = visible_q;
   assign duck_dir_right = right_q;
   assign duck_state     = state_q;
   assign duck_escaped   = escaped_q;
   assign duck_fell      = fell_q;

endmodule

// File: tb/tb_duck_flight_ctl.sv
// Bench for duck_flight_ctl: directed scenarios plus random stimulus against a behavioural model.
module tb_duck_flight_ctl;

   localparam int          MD    = 4;
   localparam int          FT    = 20;
   localparam int          STK   = 3;
   localparam int          XMAX  = 960;
   localparam int          YMAX  = 536;
   // Seed whose successor has x field 958 and heading bit set.
   localparam logic [15:0] SEED  = 16'h0F7C;

   logic        clk = 1'b0;
   logic        rst, game_enable, hunt_start, duck_hit;
   logic [11:0] duck_xpos, duck_ypos;
   logic        duck_visible, duck_dir_right, duck_escaped, duck_fell;
   logic [2:0]  duck_state;

   duck_flight_ctl #(
      .MOVE_DIV(MD), .FLY_TICKS(FT), .SHOT_TICKS(STK), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .rst(rst), .game_enable(game_enable), .hunt_start(hunt_start),
      .duck_hit(duck_hit), .duck_xpos(duck_xpos), .duck_ypos(duck_ypos),
      .duck_visible(duck_visible), .duck_dir_right(duck_dir_right),
      .duck_state(duck_state), .duck_escaped(duck_escaped), .duck_fell(duck_fell)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   bit cmp_en  = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
   endtask

   // Behavioural model: phases as plain ints, movement by arithmetic on pixel coordinates.
   int          m_state = 0, m_x = 0, m_y = 0, m_cnt = 0, m_fly = 0, m_shot = 0;
   bit          m_right = 0, m_up = 0, m_vis = 0, m_esc = 0, m_fell = 0, m_hprev = 0;
   int unsigned m_lfsr = 0;

   function automatic int unsigned lfsr_next(input int unsigned s);
      return (s >> 1) ^ (((s & 1) != 0) ? 32'hB400 : 32'h0);
   endfunction

   always @(posedge clk) begin : model
      int nst;
      bit tick;
      if (rst) begin
         m_state = 0; m_x = 0; m_y = 0; m_cnt = 0; m_fly = 0; m_shot = 0;
         m_right = 0; m_up = 0; m_vis = 0; m_esc = 0; m_fell = 0; m_hprev = 0;
         m_lfsr  = SEED;
      end else begin
         tick   = (m_state != 0) && (m_cnt == MD - 1);
         nst    = m_state;
         m_esc  = 0;
         m_fell = 0;
         if (!game_enable) nst = 0;
         else begin
            case (m_state)
               0: if (hunt_start && !m_hprev) nst = 1;
               1: begin
                  m_x = m_lfsr % 1024;
                  if (m_x > XMAX) m_x = m_x - 512;
                  m_y = YMAX; m_right = ((m_lfsr >> 10) & 1) != 0; m_up = 1; m_fly = 0;
                  nst = 2;
               end
               2: if (duck_hit) begin
                  nst = 3; m_shot = 0;
               end else if (tick) begin
                  if (m_right) begin
                     if (m_x + 4 > XMAX) begin m_x = XMAX; m_right = 0; end
                     else m_x = m_x + 4;
                  end else begin
                     if (m_x < 4) begin m_x = 0; m_right = 1; end
                     else m_x = m_x - 4;
                  end
                  if (m_up) begin
                     if (m_y < 4) begin m_y = 0; m_up = 0; end
                     else m_y = m_y - 4;
                  end else begin
                     if (m_y + 4 > YMAX) begin m_y = YMAX; m_up = 1; end
                     else m_y = m_y + 4;
                  end
                  if ((m_fly % 32) == 31 && (m_lfsr & 1) != 0) m_right = !m_right;
                  m_fly++;
                  if (m_fly == FT) nst = 5;
               end
               3: if (tick) begin
                  m_shot++;
                  if (m_shot == STK) nst = 4;
               end
               4: if (tick) begin
                  if (m_y + 8 >= YMAX) begin m_y = YMAX; m_fell = 1; nst = 0; end
                  else m_y = m_y + 8;
               end
               5: if (tick) begin
                  if (m_y < 4) begin m_y = 0; m_esc = 1; nst = 0; end
                  else m_y = m_y - 4;
               end
               default: nst = 0;
            endcase
         end
         m_cnt   = (m_state == 0) ? 0 : (m_cnt + 1) % MD;
         m_lfsr  = lfsr_next(m_lfsr);
         m_hprev = hunt_start;
         m_state = nst;
         m_vis   = (nst != 0);
      end
   end

   int esc_seen = 0, fell_seen = 0;

   always @(negedge clk) begin
      if (duck_escaped) esc_seen++;
      if (duck_fell) fell_seen++;
      if (cmp_en) begin
         chk("xpos", duck_xpos, m_x);
         chk("ypos", duck_ypos, m_y);
         chk("visible", duck_visible, m_vis);
         chk("dir_right", duck_dir_right, m_right);
         chk("state", duck_state, m_state);
         chk("escaped", duck_escaped, m_esc);
         chk("fell", duck_fell, m_fell);
      end
   end

   task automatic wait_state(input string name, input int st, input int lim);
      int n = 0;
      while (int'(duck_state) != st && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(name, duck_state, st);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int base, n;
      rst = 1'b1; game_enable = 1'b0; hunt_start = 1'b0; duck_hit = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cmp_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      chk("idle_state", duck_state, 0);
      chk("idle_x", duck_xpos, 0);
      chk("idle_y", duck_ypos, 0);
      chk("idle_vis", duck_visible, 0);

      // Spawn and first tick
      game_enable = 1'b1; hunt_start = 1'b1;
      @(negedge clk);
      chk("spawn_state", duck_state, 1);
      @(negedge clk);
      chk("fly_state", duck_state, 2);
      chk("fly_y0", duck_ypos, 536);
      chk("fly_x_in_range", (duck_xpos <= 12'd960) ? 1 : 0, 1);
      chk("fly_vis", duck_visible, 1);
      repeat (3) @(negedge clk);
      chk("first_tick_y", duck_ypos, 532);
      hunt_start = 1'b0;

      // Escape after FLY_TICKS without a hit
      base = esc_seen;
      wait_state("escape_entry", 5, 200);
      chk("escape_entry_y", duck_ypos, 536 - 4 * FT);
      n = 0;
      while (!duck_escaped && n < 1000) begin @(negedge clk); n++; end
      chk("escaped_seen", duck_escaped, 1);
      chk("escaped_y", duck_ypos, 0);
      chk("escaped_idle", duck_state, 0);
      repeat (10) @(negedge clk);
      chk("escaped_once", esc_seen - base, 1);

      // Hit after 5 ticks, shot freeze, fall with clamp
      hunt_start = 1'b1;
      wait_state("hit_fly", 2, 20);
      n = 0;
      while (m_fly != 5 && n < 200) begin @(negedge clk); n++; end
      chk("hit_pre_y", duck_ypos, 516);
      duck_hit = 1'b1;
      @(negedge clk);
      duck_hit = 1'b0;
      chk("shot_state", duck_state, 3);
      chk("shot_y", duck_ypos, 516);
      base = fell_seen;
      wait_state("fall_entry", 4, 100);
      chk("fall_entry_y", duck_ypos, 516);
      duck_hit = 1'b1;
      @(negedge clk);
      duck_hit = 1'b0;
      chk("fall_ignores_hit", duck_state, 4);
      n = 0;
      while (!duck_fell && n < 100) begin @(negedge clk); n++; end
      chk("fell_seen", duck_fell, 1);
      chk("fell_y", duck_ypos, 536);
      chk("fell_idle", duck_state, 0);
      repeat (10) @(negedge clk);
      chk("fell_once", fell_seen - base, 1);

      // Bounce off the right edge from a seeded spawn at x=958
      rst = 1'b1; hunt_start = 1'b1; game_enable = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("bounce_spawn", duck_state, 1);
      @(negedge clk);
      chk("bounce_x0", duck_xpos, 958);
      chk("bounce_dir0", duck_dir_right, 1);
      repeat (3) @(negedge clk);
      chk("bounce_x1", duck_xpos, 960);
      chk("bounce_dir1", duck_dir_right, 0);
      repeat (4) @(negedge clk);
      chk("bounce_x2", duck_xpos, 956);
      chk("bounce_y2", duck_ypos, 528);
      n = 0;
      while (m_cnt != MD - 1 && n < 10) begin @(negedge clk); n++; end
      duck_hit = 1'b1;
      @(negedge clk);
      duck_hit = 1'b0;
      chk("hit_on_tick_state", duck_state, 3);
      chk("hit_on_tick_x", duck_xpos, 956);
      chk("hit_on_tick_y", duck_ypos, 528);
      wait_state("bounce_done", 0, 200);

      // Abort mid-flight; FLY-time hunt_start edge must not respawn
      hunt_start = 1'b0;
      @(negedge clk);
      hunt_start = 1'b1;
      wait_state("abort_fly", 2, 10);
      repeat (5) @(negedge clk);
      hunt_start = 1'b0;
      @(negedge clk);
      hunt_start = 1'b1;
      @(negedge clk);
      chk("edge_in_fly", duck_state, 2);
      game_enable = 1'b0;
      @(negedge clk);
      chk("abort_state", duck_state, 0);
      chk("abort_vis", duck_visible, 0);
      chk("abort_esc", duck_escaped, 0);
      chk("abort_fell", duck_fell, 0);
      game_enable = 1'b1;
      repeat (10) @(negedge clk);
      chk("no_respawn", duck_state, 0);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         game_enable = ($urandom_range(99) < 98);
         if ($urandom_range(99) < 5) hunt_start = !hunt_start;
         duck_hit = ($urandom_range(99) < 1);
         rst = ($urandom_range(999) == 0);
         @(negedge clk);
      end
      rst = 1'b0; duck_hit = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
